// File: rtl/bpsk_frame_pkg.sv
// Shared types and constants for the BPSK frame source: FSM states,
// default sync pattern and the PN9 generator definition.
package bpsk_frame_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        SYNC = 3'd2,
        PAY  = 3'd3,
        GAP  = 3'd4
    } state_t;

    localparam logic [15:0] SYNC_DEFAULT = 16'hEB90;
    localparam logic [8:0]  PN9_SEED     = 9'h1FF;
    localparam int          PN9_TAP_HI   = 8;
    localparam int          PN9_TAP_LO   = 4;

    // x^9 + x^5 + 1 feedback bit for a left-shifting Fibonacci register
    function automatic logic pn9_feedback(input logic [8:0] s);
        return s[PN9_TAP_HI] ^ s[PN9_TAP_LO];
    endfunction

endpackage

// File: rtl/pn9_lfsr.sv
// PN9 payload generator; bit_out is the register MSB, so the current
// payload bit is available before the advance that consumes it.
module pn9_lfsr
    import bpsk_frame_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic seed_load,
    input  logic advance,
    output logic bit_out
);

    logic [8:0] lfsr_r;

    // LFSR state: reseed at frame start, shift once per payload bit
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= PN9_SEED;
        end else if (seed_load) begin
            lfsr_r <= PN9_SEED;
        end else if (advance) begin
            lfsr_r <= {lfsr_r[7:0], pn9_feedback(lfsr_r)};
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign bit_out = lfsr_r[PN9_TAP_HI];

endmodule

// File: rtl/bpsk_frame_gen.sv
// Frame source for the BPSK modulator: preamble, sync word, PN9 or external
// payload and a zero gap, each bit held DIV clocks, all outputs registered.
module bpsk_frame_gen
    import bpsk_frame_pkg::*;
#(
    parameter int          DIV       = 1200,
    parameter int          PRE_LEN   = 32,
    parameter logic [15:0] SYNC_WORD = SYNC_DEFAULT,
    parameter int          PAY_LEN   = 256,
    parameter int          GAP_LEN   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       src_sel,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       base_data,
    output logic       bit_strobe,
    output logic       frame_start,
    output logic       busy,
    output logic       underrun
);

    localparam int DW      = $clog2(DIV);
    localparam int MAX_A   = (PRE_LEN > PAY_LEN) ? PRE_LEN : PAY_LEN;
    localparam int MAX_B   = (GAP_LEN > 16) ? GAP_LEN : 16;
    localparam int MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int IDX_W   = $clog2(MAX_LEN);

    localparam logic [DW-1:0]    DIV_LAST  = DW'(DIV - 1);
    localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PRE_LEN - 1);
    localparam logic [IDX_W-1:0] SYNC_LAST = IDX_W'(15);
    localparam logic [IDX_W-1:0] PAY_LAST  = IDX_W'(PAY_LEN - 1);
    localparam logic [IDX_W-1:0] GAP_LAST  = IDX_W'(GAP_LEN - 1);

    state_t            state_r, state_nxt_s;
    logic [DW-1:0]     div_cnt_r, div_nxt_s;
    logic [IDX_W-1:0]  bit_idx_r, idx_nxt_s, idx_inc_s;
    logic [7:0]        shift_r, shift_nxt_s;
    logic [7:0]        buf_r, buf_nxt_s;
    logic              buf_full_r, buf_full_nxt_s;
    logic              src_sel_r, src_nxt_s;
    logic              underrun_r, underrun_nxt_s;
    logic              base_data_r, base_nxt_s;
    logic              bit_strobe_r, strobe_nxt_s;
    logic              frame_start_r, fstart_nxt_s;
    logic              busy_r, in_ready_r;
    logic              boundary_s, start_s, pay_bit_s, byte_start_s;
    logic              seed_load_s, advance_s, pn_bit_s;
    logic [3:0]        sync_sel_s;

    assign boundary_s = (state_r != IDLE) && (div_cnt_r == DIV_LAST);
    assign idx_inc_s  = bit_idx_r + IDX_W'(1);
    assign sync_sel_s = 4'd14 - bit_idx_r[3:0];

    pn9_lfsr u_pn9 (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load_s),
        .advance   (advance_s),
        .bit_out   (pn_bit_s)
    );

    // Next-state, next-bit and byte-buffer logic
    always_comb begin
        state_nxt_s    = state_r;
        idx_nxt_s      = bit_idx_r;
        base_nxt_s     = base_data_r;
        strobe_nxt_s   = 1'b0;
        fstart_nxt_s   = 1'b0;
        shift_nxt_s    = shift_r;
        buf_nxt_s      = buf_r;
        buf_full_nxt_s = buf_full_r;
        src_nxt_s      = src_sel_r;
        underrun_nxt_s = underrun_r;
        seed_load_s    = 1'b0;
        advance_s      = 1'b0;
        start_s        = 1'b0;
        pay_bit_s      = 1'b0;
        byte_start_s   = 1'b0;

        if (state_r == IDLE || boundary_s) begin
            div_nxt_s = '0;
        end else begin
            div_nxt_s = div_cnt_r + DW'(1);
        end

        if (in_valid && in_ready_r) begin
            buf_nxt_s      = in_data;
            buf_full_nxt_s = 1'b1;
        end else begin
            buf_full_nxt_s = buf_full_r;
        end

        case (state_r)
            IDLE: begin
                base_nxt_s = 1'b0;
                start_s    = en;
            end
            PRE: begin
                if (boundary_s) begin
                    strobe_nxt_s = 1'b1;
                    if (bit_idx_r == PRE_LAST) begin
                        state_nxt_s = SYNC;
                        idx_nxt_s   = '0;
                        base_nxt_s  = SYNC_WORD[15];
                    end else begin
                        idx_nxt_s  = idx_inc_s;
                        // next bit ~(i+1)[0] equals i[0]
                        base_nxt_s = bit_idx_r[0];
                    end
                end else begin
                    idx_nxt_s = bit_idx_r;
                end
            end
            SYNC: begin
                if (boundary_s) begin
                    strobe_nxt_s = 1'b1;
                    if (bit_idx_r == SYNC_LAST) begin
                        state_nxt_s  = PAY;
                        idx_nxt_s    = '0;
                        pay_bit_s    = 1'b1;
                        byte_start_s = 1'b1;
                    end else begin
                        idx_nxt_s  = idx_inc_s;
                        base_nxt_s = SYNC_WORD[sync_sel_s];
                    end
                end else begin
                    idx_nxt_s = bit_idx_r;
                end
            end
            PAY: begin
                if (boundary_s) begin
                    strobe_nxt_s = 1'b1;
                    if (bit_idx_r == PAY_LAST) begin
                        state_nxt_s = GAP;
                        idx_nxt_s   = '0;
                        base_nxt_s  = 1'b0;
                    end else begin
                        idx_nxt_s    = idx_inc_s;
                        pay_bit_s    = 1'b1;
                        byte_start_s = (idx_inc_s[2:0] == 3'd0);
                    end
                end else begin
                    idx_nxt_s = bit_idx_r;
                end
            end
            GAP: begin
                if (boundary_s) begin
                    if (bit_idx_r == GAP_LAST) begin
                        start_s     = en;
                        state_nxt_s = IDLE;
                        idx_nxt_s   = '0;
                        base_nxt_s  = 1'b0;
                    end else begin
                        strobe_nxt_s = 1'b1;
                        idx_nxt_s    = idx_inc_s;
                        base_nxt_s   = 1'b0;
                    end
                end else begin
                    idx_nxt_s = bit_idx_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                idx_nxt_s   = '0;
                base_nxt_s  = 1'b0;
            end
        endcase

        if (start_s) begin
            state_nxt_s  = PRE;
            idx_nxt_s    = '0;
            base_nxt_s   = 1'b1;
            strobe_nxt_s = 1'b1;
            fstart_nxt_s = 1'b1;
            seed_load_s  = 1'b1;
            src_nxt_s    = src_sel;
        end else begin
            src_nxt_s = src_sel_r;
        end

        // Payload bit: PN9 output, or the byte shifter with buffer reload
        if (pay_bit_s) begin
            if (!src_sel_r) begin
                base_nxt_s = pn_bit_s;
                advance_s  = 1'b1;
            end else if (byte_start_s) begin
                if (buf_full_r) begin
                    base_nxt_s     = buf_r[7];
                    shift_nxt_s    = {buf_r[6:0], 1'b0};
                    buf_full_nxt_s = 1'b0;
                end else begin
                    base_nxt_s     = 1'b0;
                    shift_nxt_s    = 8'h00;
                    underrun_nxt_s = 1'b1;
                end
            end else begin
                base_nxt_s  = shift_r[7];
                shift_nxt_s = {shift_r[6:0], 1'b0};
            end
        end else begin
            advance_s = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            div_cnt_r     <= '0;
            bit_idx_r     <= '0;
            shift_r       <= 8'h00;
            buf_r         <= 8'h00;
            buf_full_r    <= 1'b0;
            src_sel_r     <= 1'b0;
            underrun_r    <= 1'b0;
            base_data_r   <= 1'b0;
            bit_strobe_r  <= 1'b0;
            frame_start_r <= 1'b0;
            busy_r        <= 1'b0;
            in_ready_r    <= 1'b1;
        end else begin
            state_r       <= state_nxt_s;
            div_cnt_r     <= div_nxt_s;
            bit_idx_r     <= idx_nxt_s;
            shift_r       <= shift_nxt_s;
            buf_r         <= buf_nxt_s;
            buf_full_r    <= buf_full_nxt_s;
            src_sel_r     <= src_nxt_s;
            underrun_r    <= underrun_nxt_s;
            base_data_r   <= base_nxt_s;
            bit_strobe_r  <= strobe_nxt_s;
            frame_start_r <= fstart_nxt_s;
            busy_r        <= (state_nxt_s != IDLE);
            in_ready_r    <= ~buf_full_nxt_s;
        end
    end

    assign in_ready    = in_ready_r;
    assign base_data   = base_data_r;
    assign bit_strobe  = bit_strobe_r;
    assign frame_start = frame_start_r;
    assign busy        = busy_r;
    assign underrun    = underrun_r;

endmodule

// File: tb/tb_bpsk_frame_gen.sv
// Directed bench for bpsk_frame_gen with DIV=4, PRE_LEN=4, PAY_LEN=16,
// GAP_LEN=2; every cycle of each frame is compared against the expected bit.
module tb_bpsk_frame_gen;

    logic       clk;
    logic       rst;
    logic       en;
    logic       src_sel;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       base_data;
    logic       bit_strobe;
    logic       frame_start;
    logic       busy;
    logic       underrun;

    int checks = 0;
    int errors = 0;
    logic [7:0] byte_q[$];

    bpsk_frame_gen #(
        .DIV       (4),
        .PRE_LEN   (4),
        .SYNC_WORD (16'hEB90),
        .PAY_LEN   (16),
        .GAP_LEN   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .src_sel     (src_sel),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .base_data   (base_data),
        .bit_strobe  (bit_strobe),
        .frame_start (frame_start),
        .busy        (busy),
        .underrun    (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " base_data"},   32'(base_data),   32'd0);
        check({tag, " bit_strobe"},  32'(bit_strobe),  32'd0);
        check({tag, " frame_start"}, 32'(frame_start), 32'd0);
        check({tag, " busy"},        32'(busy),        32'd0);
        check({tag, " underrun"},    32'(underrun),    32'd0);
        check({tag, " in_ready"},    32'(in_ready),    32'd1);
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, " idle base_data"},   32'(base_data),   32'd0);
            check({tag, " idle bit_strobe"},  32'(bit_strobe),  32'd0);
            check({tag, " idle frame_start"}, 32'(frame_start), 32'd0);
            check({tag, " idle busy"},        32'(busy),        32'd0);
            tick();
        end
    endtask

    // Called on the first cycle of a frame; walks all 38 bits x 4 cycles
    task automatic run_frame(input logic [15:0] pay, input int ur_mode,
                             input int drop_cyc, input string tag);
        logic [37:0] exp_frame;
        logic        exp_bit;
        logic        exp_ur;
        int          strobes;
        exp_frame = {4'b1010, 16'b1110101110010000, pay, 2'b00};
        strobes   = 0;
        for (int k = 0; k < 38; k++) begin
            for (int c = 0; c < 4; c++) begin
                exp_bit = exp_frame[37 - k];
                exp_ur  = (ur_mode == 1) ? (k >= 20) : 1'b0;
                check({tag, " base_data"},   32'(base_data),   32'(exp_bit));
                check({tag, " bit_strobe"},  32'(bit_strobe),  32'(c == 0));
                check({tag, " frame_start"}, 32'(frame_start), 32'(k == 0 && c == 0));
                check({tag, " busy"},        32'(busy),        32'd1);
                check({tag, " underrun"},    32'(underrun),    32'(exp_ur));
                if (bit_strobe) strobes++;
                if (k * 4 + c == drop_cyc) en = 1'b0;
                if (byte_q.size() > 0 && in_ready) begin
                    in_valid = 1'b1;
                    in_data  = byte_q.pop_front();
                end else begin
                    in_valid = 1'b0;
                end
                tick();
            end
        end
        in_valid = 1'b0;
        check({tag, " strobe count"}, 32'(strobes), 32'd38);
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        src_sel  = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        tick();
        tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();
        check_reset_vals("post reset");

        // Single PN9 frame, en pulsed for one cycle
        en = 1'b1;
        tick();
        en = 1'b0;
        run_frame(16'hFF83, 0, -1, "pn9 single");
        idle_check("pn9 single", 12);

        // Back-to-back frames; en dropped in the second frame's payload
        en = 1'b1;
        tick();
        run_frame(16'hFF83, 0, -1, "pn9 frame A");
        run_frame(16'hFF83, 0, 100, "pn9 frame B");
        idle_check("en drop", 12);

        // External bytes: A5 buffered in IDLE, 3C fed when in_ready rises
        src_sel  = 1'b1;
        in_data  = 8'hA5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("buffer full in_ready", 32'(in_ready), 32'd0);
        byte_q.push_back(8'h3C);
        en = 1'b1;
        tick();
        en      = 1'b0;
        src_sel = 1'b0;
        run_frame(16'hA53C, 0, -1, "ext bytes");
        idle_check("ext bytes", 4);
        check("ext underrun", 32'(underrun), 32'd0);
        check("ext in_ready", 32'(in_ready), 32'd1);

        // External source with no bytes: zero payload and sticky underrun
        src_sel = 1'b1;
        en      = 1'b1;
        tick();
        en      = 1'b0;
        src_sel = 1'b0;
        run_frame(16'h0000, 1, -1, "ext empty");
        idle_check("ext empty", 4);
        check("underrun sticky", 32'(underrun), 32'd1);

        // Reset during SYNC aborts the frame, then a clean restart
        en = 1'b1;
        tick();
        en = 1'b0;
        for (int i = 0; i < 22; i++) tick();
        check("mid-sync busy", 32'(busy), 32'd1);
        check("mid-sync underrun", 32'(underrun), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("mid-frame reset");
        tick();
        idle_check("after abort", 8);
        en = 1'b1;
        tick();
        en = 1'b0;
        run_frame(16'hFF83, 0, -1, "restart");
        idle_check("restart", 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
